// File: rtl/sad_min_tracker_pkg.sv
// Shared definitions for the SAD result stream: tracker FSM states and SAD sentinel/limit values.
package sad_min_tracker_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SCAN    = 2'd1,
        CONVERT = 2'd2,
        DONE    = 2'd3
    } trackState_t;

    localparam int unsigned SAD_SENTINEL = 9999;
    localparam logic [31:0] SAD_MAX      = 32'hFFFF_FFFF;

endpackage

// File: rtl/sad_min_tracker_seq_divider.sv
// Unsigned restoring divider, one quotient bit per cycle, MSB first; W steps per division.
// The first step is taken on the Go edge, so Done pulses in the cycle after the W-th step.
module sad_min_tracker_seq_divider #(
    parameter int W = 32
) (
    input  logic         Clk,
    input  logic         Reset,
    input  logic         Go,
    input  logic [W-1:0] Dividend,
    input  logic [W-1:0] Divisor,
    output logic [W-1:0] Quotient,
    output logic [W-1:0] Remainder,
    output logic         Done
);

    localparam int CNT_W = $clog2(W);

    logic [CNT_W-1:0] stepCount;
    logic             running;
    logic [W-1:0]     remIn;
    logic [W-1:0]     quoIn;
    logic [W-1:0]     remNext;
    logic [W-1:0]     quoNext;
    logic [W:0]       trial;

    // Quotient doubles as the shift register holding the not-yet-consumed dividend bits.
    always_comb begin
        remIn = Go ? '0 : Remainder;
        quoIn = Go ? Dividend : Quotient;
        trial = {remIn, quoIn[W-1]};
        if (trial >= {1'b0, Divisor}) begin
            remNext = W'(trial - {1'b0, Divisor});
            quoNext = {quoIn[W-2:0], 1'b1};
        end else begin
            remNext = trial[W-1:0];
            quoNext = {quoIn[W-2:0], 1'b0};
        end
    end

    // NOTE: state registers use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            Quotient  <= '0;
            Remainder <= '0;
            stepCount <= '0;
            running   <= 1'b0;
            Done      <= 1'b0;
        end else begin
            Done <= 1'b0;
            if (Go) begin
                Quotient  <= quoNext;
                Remainder <= remNext;
                stepCount <= CNT_W'(1);
                running   <= 1'b1;
            end else if (running) begin
                Quotient  <= quoNext;
                Remainder <= remNext;
                stepCount <= stepCount + CNT_W'(1);
                if (stepCount == CNT_W'(W - 1)) begin
                    running <= 1'b0;
                    Done    <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/sad_min_tracker.sv
// Tracks the minimum SAD of a search pass and converts its linear index into a (row, col) vector.
module sad_min_tracker
    import sad_min_tracker_pkg::*;
#(
    parameter int          SEARCH_W = 61,
    parameter int unsigned SENTINEL = SAD_SENTINEL,
    parameter int          DATA_W   = 32
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic              SADValid,
    input  logic              SADLast,
    input  logic [DATA_W-1:0] SADValIn,
    input  logic [DATA_W-1:0] SADIndexIn,
    output logic              Busy,
    output logic              ResultValid,
    output logic              NoMatch,
    output logic [DATA_W-1:0] BestSAD,
    output logic [DATA_W-1:0] BestIndex,
    output logic [DATA_W-1:0] BestRow,
    output logic [DATA_W-1:0] BestCol
);

    trackState_t       state;
    logic              seenSample;
    logic              sampleAccept;
    logic              isReal;
    logic              improve;
    logic              passEnd;
    logic [DATA_W-1:0] nextIndex;
    logic [DATA_W-1:0] divQuotient;
    logic [DATA_W-1:0] divRemainder;
    logic              divDone;

    // Start wins over a coincident sample, so the sample is never accepted.
    assign sampleAccept = (state == SCAN) && SADValid && !Start;
    assign isReal       = SADValIn != DATA_W'(SENTINEL);
    assign improve      = sampleAccept && isReal && (SADValIn < BestSAD);
    assign passEnd      = sampleAccept && SADLast;
    assign nextIndex    = improve ? SADIndexIn : BestIndex;

    sad_min_tracker_seq_divider #(
        .W (DATA_W)
    ) u_divider (
        .Clk       (Clk),
        .Reset     (Reset),
        .Go        (passEnd),
        .Dividend  (nextIndex),
        .Divisor   (DATA_W'(SEARCH_W)),
        .Quotient  (divQuotient),
        .Remainder (divRemainder),
        .Done      (divDone)
    );

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state       <= IDLE;
            Busy        <= 1'b0;
            ResultValid <= 1'b0;
            NoMatch     <= 1'b0;
            BestSAD     <= '1;
            BestIndex   <= '0;
            BestRow     <= '0;
            BestCol     <= '0;
            seenSample  <= 1'b0;
        end else if (Start) begin
            state       <= SCAN;
            Busy        <= 1'b1;
            ResultValid <= 1'b0;
            NoMatch     <= 1'b0;
            BestSAD     <= '1;
            BestIndex   <= '0;
            BestRow     <= '0;
            BestCol     <= '0;
            seenSample  <= 1'b0;
        end else begin
            case (state)
                SCAN: begin
                    if (improve) begin
                        BestSAD   <= SADValIn;
                        BestIndex <= SADIndexIn;
                    end
                    if (sampleAccept && isReal)
                        seenSample <= 1'b1;
                    if (passEnd)
                        state <= CONVERT;
                end
                // A Done left over from an aborted conversion lands in SCAN and is dropped there.
                CONVERT: begin
                    if (divDone) begin
                        BestRow     <= divQuotient;
                        BestCol     <= divRemainder;
                        NoMatch     <= !seenSample;
                        state       <= DONE;
                        Busy        <= 1'b0;
                        ResultValid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
